sne_spike_event_tx: RTL and testbench
=====================================

Name: sne_spike_event_tx

Overview:
- Output side of a neuron cluster: collects spike_o pulses from the neuron datapath and turns them into address-event words on a valid/ready stream.
- Tags each accepted spike with neuron address and time step.
- Inserts an end-of-time-step marker word.
- Buffers in a small FIFO so downstream stalls do not drop events when capacity allows.

Parameters:
NID_WIDTH, 16, neuron address width
TIME_WIDTH, 8, time-step stamp width
FIFO_DEPTH, 8, event buffer entries; power of two, >= 2
CNT_WIDTH, 16, drop counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clr_i  in  1  synchronous clear of FIFO, pending marker, counter
spike_valid_i  in  1  neuron spike_o qualified for this neuron update
spike_ready_o  out  1  spike can be accepted this cycle
neuron_id_i  in  NID_WIDTH  address of spiking neuron
time_i  in  TIME_WIDTH  current time step
step_done_i  in  1  single-cycle pulse: all neurons of time_i processed
evt_valid_o  out  1  event word available
evt_ready_i  in  1  downstream accepts event
evt_data_o  out  1+TIME_WIDTH+NID_WIDTH  {type, time, id}; type 0 = spike, 1 = step marker (id field = 0)
fifo_level_o  out  $clog2(FIFO_DEPTH)+1  occupied entries
drop_cnt_o  out  CNT_WIDTH  spikes lost to backpressure

Behaviour:
- Reset (rst_ni low, asynchronous): FIFO empty; pointers 0; marker_pending 0; drop counter 0.
  - Reset output values: evt_valid_o 0, evt_data_o 0, fifo_level_o 0, spike_ready_o 1.
  - Reset mid-transfer discards all buffered words.
- FIFO: register array, rd/wr pointers with extra wrap bit; full when pointers differ only in the MSB.
  - evt_data_o = entry at rd pointer; evt_valid_o = not empty.
  - Pop on evt_valid_o && evt_ready_i.
- spike_ready_o = !full && !marker_pending. Combinational; depends only on state, never on evt_ready_i (no full-and-pop bypass).
- Spike write: on spike_valid_i && spike_ready_o, entry {0, time_i, neuron_id_i} is written at the edge.
  - evt_valid_o rises in the following cycle (1-cycle latency when empty).
- Marker:
  - step_done_i sets marker_pending and latches time_i into marker_time.
  - While pending and !full, entry {1, marker_time, 0} is written and pending clears the same edge.
  - A pending marker has priority over new spikes (spike_ready_o low), so markers stay ordered after the step's spikes.
- Simultaneous events:
  - Spike accepted and step_done_i in the same cycle: spike written this edge; marker written no earlier than the next edge.
  - step_done_i while marker_pending already set: the new pulse is ignored (protocol violation) and the old marker_time is kept.
  - Push and pop in the same cycle: level unchanged; pointers both advance.
- At most one write per cycle.
- Drop: spike_valid_i && !spike_ready_o increments the drop counter; it saturates at all-ones and never wraps.
- clr_i: same effect as reset at the next edge. Has priority over push, pop and marker.
- Holding rule: evt_data_o is stable while evt_valid_o && !evt_ready_i.

Optional Feature:
SNE_SPIKE_TX_DROP_CNT_EN
- Defined: drop counter implemented as above.
- Undefined: no counter registers; drop_cnt_o tied to 0; drops still occur silently.

Test Plan:
- Single spike, empty FIFO, evt_ready_i=1: id=0x0012, time=5 at cycle 0 -> evt_valid_o=1 cycle 1, evt_data_o={0,0x05,0x0012}, popped, level back to 0.
- Fill with evt_ready_i=0: 8 spikes id 0..7 -> level 8, spike_ready_o=0. A 9th spike -> drop_cnt_o=1. Release ready -> ids 0..7 emerge in order.
- Spike id=3 and step_done_i same cycle at time=9 -> words {0,9,3} then {1,9,0}. Spike offered next cycle is stalled (spike_ready_o=0) until the marker is written.
- FIFO full with marker pending, then pop one entry -> marker written on the next edge; spike_ready_o returns to 1 one cycle later.
- Drop counter saturation with CNT_WIDTH=4: 20 stalled spikes -> drop_cnt_o=15. clr_i -> drop_cnt_o=0, level 0, evt_valid_o=0.
- rst_ni asserted mid-stream with level 5 -> evt_valid_o=0 immediately. After release, first new spike is output correctly from pointer 0.

Source files
------------

// File: rtl/sne_spike_event_tx.sv
// Spike-to-address-event transmitter: tags spikes with {time, id}, appends a step marker, buffers in a FIFO.
// Optional drop counter enabled by defining SNE_SPIKE_TX_DROP_CNT_EN; otherwise drop_cnt_o is tied to 0.
module sne_spike_event_tx #(
    parameter int NID_WIDTH  = 16,
    parameter int TIME_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clr_i,
    input  logic                                 spike_valid_i,
    output logic                                 spike_ready_o,
    input  logic [NID_WIDTH-1:0]                 neuron_id_i,
    input  logic [TIME_WIDTH-1:0]                time_i,
    input  logic                                 step_done_i,
    output logic                                 evt_valid_o,
    input  logic                                 evt_ready_i,
    output logic [NID_WIDTH+TIME_WIDTH:0]        evt_data_o,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level_o,
    output logic [CNT_WIDTH-1:0]                 drop_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 1 + TIME_WIDTH + NID_WIDTH;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [DW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic                  r_marker_pending;
    logic [TIME_WIDTH-1:0] r_marker_time;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_spk_wr;
    logic          w_mark_wr;
    logic          w_push;
    logic [DW-1:0] w_wdata;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = !w_empty && evt_ready_i;
    // A pending marker blocks spikes, so the two write sources never collide.
    assign w_mark_wr = r_marker_pending && !w_full;
    assign w_spk_wr  = spike_valid_i && spike_ready_o;
    assign w_push    = w_mark_wr || w_spk_wr;
    assign w_wdata   = w_mark_wr ? {1'b1, r_marker_time, {NID_WIDTH{1'b0}}}
                                 : {1'b0, time_i, neuron_id_i};

    assign spike_ready_o = !w_full && !r_marker_pending;
    assign evt_valid_o   = !w_empty;
    assign evt_data_o    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign fifo_level_o  = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk_i) begin
        if (w_push && !clr_i) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_marker_pending <= 1'b0;
            r_marker_time    <= '0;
        end else if (clr_i) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_marker_pending <= 1'b0;
            r_marker_time    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // A second step_done while a marker is still queued is dropped; the first time stamp wins.
            if (r_marker_pending) begin
                if (w_mark_wr) begin
                    r_marker_pending <= 1'b0;
                end
            end else if (step_done_i) begin
                r_marker_pending <= 1'b1;
                r_marker_time    <= time_i;
            end
        end
    end

`ifdef SNE_SPIKE_TX_DROP_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    logic                 w_drop;
    logic [CNT_WIDTH-1:0] r_drop_cnt;

    assign w_drop = spike_valid_i && !spike_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
        end else if (clr_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CNT_ONE;
        end
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sne_spike_event_tx.sv
// Scoreboard bench for sne_spike_event_tx: stimulus pushes expected words, a monitor checks each popped word.
module tb_sne_spike_event_tx;
    localparam int NW = 16;
    localparam int TW = 8;
    localparam int CW = 4;
    localparam int DW = 1 + TW + NW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clr_i = 1'b0;
    logic          spike_valid_i = 1'b0;
    logic          spike_ready_o;
    logic [NW-1:0] neuron_id_i = '0;
    logic [TW-1:0] time_i = '0;
    logic          step_done_i = 1'b0;
    logic          evt_valid_o;
    logic          evt_ready_i = 1'b0;
    logic [DW-1:0] evt_data_o;
    logic [3:0]    fifo_level_o;
    logic [CW-1:0] drop_cnt_o;

    sne_spike_event_tx #(.NID_WIDTH(NW), .TIME_WIDTH(TW), .FIFO_DEPTH(8), .CNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i),
        .spike_valid_i(spike_valid_i), .spike_ready_o(spike_ready_o),
        .neuron_id_i(neuron_id_i), .time_i(time_i), .step_done_i(step_done_i),
        .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_data_o(evt_data_o),
        .fifo_level_o(fifo_level_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;
    int exp_drop = 0;
    logic [DW-1:0] sb[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic int drop_exp();
`ifdef SNE_SPIKE_TX_DROP_CNT_EN
        return exp_drop;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk_i) begin
        if (rst_ni && evt_valid_o && evt_ready_i) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_word: got %0h expected none", evt_data_o);
            end else begin
                check("evt_data", 32'(evt_data_o), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic spike(input logic [NW-1:0] id, input logic [TW-1:0] t, input bit acc, input bit sd = 1'b0);
        check("spike_ready", 32'(spike_ready_o), 32'(acc));
        spike_valid_i = 1'b1;
        neuron_id_i   = id;
        time_i        = t;
        step_done_i   = sd;
        if (acc) sb.push_back({1'b0, t, id});
        else if (exp_drop < 15) exp_drop++;
        tick();
        spike_valid_i = 1'b0;
        step_done_i   = 1'b0;
    endtask

    task automatic drain();
        int n;
        evt_ready_i = 1'b1;
        n = 0;
        while ((sb.size() != 0 || fifo_level_o != 0) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            n_chk++;
            $display("FAIL drain_timeout: got level %0d expected 0", fifo_level_o);
        end
        evt_ready_i = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_valid", 32'(evt_valid_o), 0);
        check("rst_data", 32'(evt_data_o), 0);
        check("rst_level", 32'(fifo_level_o), 0);
        check("rst_ready", 32'(spike_ready_o), 1);
        check("rst_drop", 32'(drop_cnt_o), 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // single spike, ready high
        evt_ready_i = 1'b1;
        spike(16'h0012, 8'd5, 1'b1);
        check("t1_valid", 32'(evt_valid_o), 1);
        check("t1_level1", 32'(fifo_level_o), 1);
        tick();
        check("t1_level0", 32'(fifo_level_o), 0);
        check("t1_valid0", 32'(evt_valid_o), 0);

        // fill, overflow, drain in order
        evt_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) spike(NW'(i), 8'd1, 1'b1);
        check("fill_level", 32'(fifo_level_o), 8);
        spike(16'h0008, 8'd1, 1'b0);
        check("fill_drop", 32'(drop_cnt_o), 32'(drop_exp()));
        drain();

        // spike and step_done together, next spike stalls one cycle
        spike(16'h0003, 8'd9, 1'b1, 1'b1);
        spike(16'h0004, 8'd9, 1'b0);
        sb.push_back({1'b1, 8'd9, 16'h0000});
        spike(16'h0004, 8'd9, 1'b1);
        check("sim_level", 32'(fifo_level_o), 3);
        drain();

        // full with pending marker, pop frees room for marker
        for (int i = 0; i < 8; i++) spike(NW'(16'h10 + i), 8'd2, 1'b1);
        time_i = 8'd2;
        step_done_i = 1'b1;
        tick();
        step_done_i = 1'b0;
        time_i = 8'd3;
        check("mk_full_ready", 32'(spike_ready_o), 0);
        check("mk_full_level", 32'(fifo_level_o), 8);
        sb.push_back({1'b1, 8'd2, 16'h0000});
        evt_ready_i = 1'b1;
        tick();
        check("mk_pend_level", 32'(fifo_level_o), 7);
        check("mk_pend_ready", 32'(spike_ready_o), 0);
        tick();
        check("mk_wr_level", 32'(fifo_level_o), 7);
        check("mk_wr_ready", 32'(spike_ready_o), 1);
        drain();

        // drop saturation then clear
        for (int i = 0; i < 8; i++) spike(NW'(16'h20 + i), 8'd4, 1'b1);
        for (int i = 0; i < 20; i++) spike(NW'(16'h40 + i), 8'd4, 1'b0);
        check("sat_drop", 32'(drop_cnt_o), 32'(drop_exp()));
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        sb.delete();
        exp_drop = 0;
        check("clr_drop", 32'(drop_cnt_o), 0);
        check("clr_level", 32'(fifo_level_o), 0);
        check("clr_valid", 32'(evt_valid_o), 0);
        check("clr_ready", 32'(spike_ready_o), 1);

        // async reset mid-stream
        for (int i = 0; i < 5; i++) spike(NW'(16'h30 + i), 8'd6, 1'b1);
        check("rs_level5", 32'(fifo_level_o), 5);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rs_valid", 32'(evt_valid_o), 0);
        check("rs_level", 32'(fifo_level_o), 0);
        sb.delete();
        tick();
        rst_ni = 1'b1;
        tick();
        evt_ready_i = 1'b1;
        spike(16'h0055, 8'd7, 1'b1);
        check("rs_new_valid", 32'(evt_valid_o), 1);
        drain();

        check("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
